// File: rtl/exe_mem_pkg.sv
// Shared types and constants for the EXE->MEM boundary stage.
package exe_mem_pkg;

  localparam int unsigned EM_DATA_W     = 32;
  localparam int unsigned EM_REG_ADDR_W = 4;
  localparam int unsigned STATUS_W      = 4;

  localparam int unsigned STATUS_N = 3;
  localparam int unsigned STATUS_Z = 2;
  localparam int unsigned STATUS_C = 1;
  localparam int unsigned STATUS_V = 0;

  typedef struct packed {
    logic [EM_DATA_W-1:0]     res;
    logic                     wb_en;
    logic                     mem_r_en;
    logic                     mem_w_en;
    logic [EM_REG_ADDR_W-1:0] dest;
    logic [EM_DATA_W-1:0]     st_val;
  } exe_mem_entry_t;

  localparam int unsigned ENTRY_W = $bits(exe_mem_entry_t);

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; ready and valid come
// straight from state so neither side sees a combinational path through it.
module skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_valid;
  logic         r_skid_valid;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_accept;
  logic         w_handoff;

  assign w_accept  = i_valid & ~r_skid_valid & ~i_flush;
  assign w_handoff = r_main_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (i_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid) begin
      if (w_accept) begin
        r_main       <= i_data;
        r_main_valid <= 1'b1;
      end
    end else if (!w_handoff) begin
      // Head stalled: a new entry parks in the skid slot.
      if (w_accept) begin
        r_skid       <= i_data;
        r_skid_valid <= 1'b1;
      end
    end else if (r_skid_valid) begin
      r_main       <= r_skid;
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_main <= i_data;
    end else begin
      r_main_valid <= 1'b0;
    end
  end

  assign o_ready = ~r_skid_valid;
  assign o_valid = r_main_valid;
  assign o_data  = r_main;

endmodule

// File: rtl/exe_mem_skid_stage.sv
// EXE->MEM pipeline stage: skid-buffered entry handoff plus the NZCV register.
// Optional forwarding outputs enabled by defining EXE_MEM_FWD_EN.
module exe_mem_skid_stage
  import exe_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = EM_DATA_W,
  parameter int unsigned REG_ADDR_W = EM_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_res,
  input  logic [3:0]            in_status,
  input  logic                  in_s,
  input  logic                  in_wb_en,
  input  logic                  in_mem_r_en,
  input  logic                  in_mem_w_en,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]     in_st_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_res,
  output logic                  out_wb_en,
  output logic                  out_mem_r_en,
  output logic                  out_mem_w_en,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [DATA_W-1:0]     out_st_val,
`ifdef EXE_MEM_FWD_EN
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0]     fwd_res,
`endif
  output logic [3:0]            status_q,
  output logic                  carry_out
);

  exe_mem_entry_t      w_in_entry;
  exe_mem_entry_t      w_head;
  logic [ENTRY_W-1:0]  w_head_bits;
  logic                w_accept;
  logic [STATUS_W-1:0] r_status;

  always_comb begin
    w_in_entry          = '0;
    w_in_entry.res      = in_res;
    w_in_entry.wb_en    = in_wb_en;
    w_in_entry.mem_r_en = in_mem_r_en;
    w_in_entry.mem_w_en = in_mem_w_en;
    w_in_entry.dest     = in_dest;
    w_in_entry.st_val   = in_st_val;
  end

  skid_buf #(.W(ENTRY_W)) u_skid_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_entry),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_head_bits)
  );

  assign w_head       = exe_mem_entry_t'(w_head_bits);
  assign out_res      = w_head.res;
  assign out_wb_en    = w_head.wb_en;
  assign out_mem_r_en = w_head.mem_r_en;
  assign out_mem_w_en = w_head.mem_w_en;
  assign out_dest     = w_head.dest;
  assign out_st_val   = w_head.st_val;

  // Flags commit at accept, independent of how long the entry stalls later.
  assign w_accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else if (w_accept && in_s) begin
      r_status <= in_status;
    end
  end

  assign status_q  = r_status;
  assign carry_out = r_status[STATUS_C];

`ifdef EXE_MEM_FWD_EN
  // Load data is not available yet at this point, so loads never forward.
  assign fwd_valid = out_valid & w_head.wb_en & ~w_head.mem_r_en;
  assign fwd_dest  = w_head.dest;
  assign fwd_res   = w_head.res;
`endif

endmodule

// File: tb/tb_exe_mem_skid_stage.sv
// Self-checking bench for exe_mem_skid_stage: directed cases plus random traffic
// compared against a queue-based model of the stage.
module tb_exe_mem_skid_stage;
  import exe_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res;
  logic [3:0]  in_status;
  logic        in_s;
  logic        in_wb_en;
  logic        in_mem_r_en;
  logic        in_mem_w_en;
  logic [3:0]  in_dest;
  logic [31:0] in_st_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_wb_en;
  logic        out_mem_r_en;
  logic        out_mem_w_en;
  logic [3:0]  out_dest;
  logic [31:0] out_st_val;
  logic [3:0]  status_q;
  logic        carry_out;
`ifdef EXE_MEM_FWD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_res;
`endif

  exe_mem_skid_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_res       (in_res),
    .in_status    (in_status),
    .in_s         (in_s),
    .in_wb_en     (in_wb_en),
    .in_mem_r_en  (in_mem_r_en),
    .in_mem_w_en  (in_mem_w_en),
    .in_dest      (in_dest),
    .in_st_val    (in_st_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_res      (out_res),
    .out_wb_en    (out_wb_en),
    .out_mem_r_en (out_mem_r_en),
    .out_mem_w_en (out_mem_w_en),
    .out_dest     (out_dest),
    .out_st_val   (out_st_val),
`ifdef EXE_MEM_FWD_EN
    .fwd_valid    (fwd_valid),
    .fwd_dest     (fwd_dest),
    .fwd_res      (fwd_res),
`endif
    .status_q     (status_q),
    .carry_out    (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an in-order queue of at most two entries plus NZCV.
  exe_mem_entry_t mq[$];
  logic [3:0]     ms;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    exe_mem_entry_t h;
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("status_q", 64'(status_q), 64'(ms));
    chk("carry_out", 64'(carry_out), 64'(ms[1]));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("out_res", 64'(out_res), 64'(h.res));
      chk("out_ctrl", 64'({out_wb_en, out_mem_r_en, out_mem_w_en, out_dest, out_st_val}),
          64'({h.wb_en, h.mem_r_en, h.mem_w_en, h.dest, h.st_val}));
    end
`ifdef EXE_MEM_FWD_EN
    chk("fwd_valid", 64'(fwd_valid), 64'((mq.size() > 0) && mq[0].wb_en && !mq[0].mem_r_en));
    if (mq.size() > 0) begin
      chk("fwd_dest", 64'(fwd_dest), 64'(mq[0].dest));
      chk("fwd_res", 64'(fwd_res), 64'(mq[0].res));
    end
`endif
  endtask

  // Advance one clock: model follows the accept/handoff/flush rules, then compare.
  task automatic tick();
    exe_mem_entry_t e;
    bit acc, ho, fl, s;
    logic [3:0] st;
    e.res = in_res; e.wb_en = in_wb_en; e.mem_r_en = in_mem_r_en;
    e.mem_w_en = in_mem_w_en; e.dest = in_dest; e.st_val = in_st_val;
    fl  = flush;
    acc = in_valid && (mq.size() < 2) && !fl;
    ho  = (mq.size() > 0) && out_ready;
    s   = in_s;
    st  = in_status;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (ho) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(e);
        if (s) ms = st;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input bit v, input logic [31:0] res, input bit s, input logic [3:0] st);
    in_valid = v; in_res = res; in_s = s; in_status = st;
    in_wb_en = 1'b1; in_mem_r_en = 1'b0; in_mem_w_en = 1'b0;
    in_dest = res[3:0]; in_st_val = ~res;
  endtask

  task automatic drive_rand();
    in_valid    = ($urandom_range(0, 9) < 7);
    in_res      = $urandom;
    in_status   = 4'($urandom);
    in_s        = 1'($urandom);
    in_wb_en    = 1'($urandom);
    in_mem_r_en = 1'($urandom);
    in_mem_w_en = 1'($urandom);
    in_dest     = 4'($urandom);
    in_st_val   = $urandom;
    out_ready   = ($urandom_range(0, 9) < 6);
    flush       = ($urandom_range(0, 15) == 0);
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_status_q", 64'(status_q), 64'd0);
    chk("rst_out_res", 64'(out_res), 64'd0);
    chk("rst_carry_out", 64'(carry_out), 64'd0);
    mq.delete();
    ms = 4'd0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_model();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 4'd0);
    ms = 4'd0;
    do_reset();

    // Streaming with MEM always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i), 1'b0, 4'd0);
      tick();
      chk("stream_res", 64'(out_res), 64'(i));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, 32'd0, 1'b0, 4'd0);
    tick();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure fills both entries, then drains in order.
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b0, 4'd0);
    tick();
    drive(1'b1, 32'hB, 1'b0, 4'd0);
    tick();
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_a", 64'(out_res), 64'hA);
    drive(1'b0, 32'd0, 1'b0, 4'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", 64'(out_res), 64'hB);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flag updates.
    drive(1'b1, 32'h5, 1'b1, 4'b0110);
    tick();
    chk("flags_set", 64'(status_q), 64'b0110);
    chk("flags_carry", 64'(carry_out), 64'd1);
    drive(1'b1, 32'h6, 1'b0, 4'b1001);
    tick();
    chk("flags_hold", 64'(status_q), 64'b0110);
    drive(1'b0, 32'd0, 1'b0, 4'd0);
    tick();

    // Flush with both entries full and a flag-setting entry incoming.
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b0, 4'd0);
    tick();
    drive(1'b1, 32'h22, 1'b0, 4'd0);
    tick();
    drive(1'b1, 32'h33, 1'b1, 4'b1111);
    flush = 1'b1;
    tick();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_status", 64'(status_q), 64'b0110);
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 4'd0);
    out_ready = 1'b1;
    tick();
    chk("flush_no_ghost", 64'(out_valid), 64'd0);

`ifdef EXE_MEM_FWD_EN
    out_ready = 1'b0;
    drive(1'b1, 32'h1234, 1'b0, 4'd0);
    in_dest = 4'd5;
    tick();
    chk("fwd_valid_alu", 64'(fwd_valid), 64'd1);
    chk("fwd_dest_5", 64'(fwd_dest), 64'd5);
    chk("fwd_res_1234", 64'(fwd_res), 64'h1234);
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0; in_valid = 1'b1; in_mem_r_en = 1'b1;
    tick();
    chk("fwd_valid_load", 64'(fwd_valid), 64'd0);
    in_valid = 1'b0; in_mem_r_en = 1'b0; out_ready = 1'b1;
    tick();
`endif

    // Random traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      drive_rand();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
